// File: rtl/wb_burst_master_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_burst_master_pkg
// Brief   : Wishbone cycle-type codes and burst-master FSM state encodings.
// Revision: 1.0 - initial release
// ============================================================================
package wb_burst_master_pkg;

    localparam logic [2:0] c_cti_classic = 3'b000;
    localparam logic [2:0] c_cti_incr    = 3'b010;
    localparam logic [2:0] c_cti_eob     = 3'b111;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_gap  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

endpackage
`default_nettype wire

// File: rtl/wb_burst_master_rd_skid.sv
`default_nettype none
// ============================================================================
// Module  : wbm_rd_skid
// Brief   : Read-data holding register with valid/ready and strobe-allow.
// Revision: 1.0 - initial release
// ============================================================================
module wbm_rd_skid #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_stb_allow
);

    logic          r_valid;
    logic [DW-1:0] r_data;

    // A new load wins over a simultaneous drain: the consumer took the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid     = r_valid;
    assign o_data      = r_data;
    assign o_stb_allow = ~r_valid | i_ready;

endmodule
`default_nettype wire

// File: rtl/wb_burst_master.sv
`default_nettype none
// ============================================================================
// Module  : wb_burst_master
// Brief   : Splits block commands into incrementing Wishbone bursts.
//           Optional ack timeout enabled by macro WBM_ACK_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module wb_burst_master
    import wb_burst_master_pkg::*;
#(
    parameter int APP_AW    = 26,
    parameter int dw        = 32,
    parameter int bl        = 9,
    parameter int MAX_BURST = 8,
    parameter int TO_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [APP_AW-1:0] cmd_addr,
    input  logic [bl-1:0]     cmd_len,
    input  logic              wd_valid,
    input  logic [dw-1:0]     wd_data,
    output logic              wd_ready,
    output logic              rd_valid,
    output logic [dw-1:0]     rd_data,
    input  logic              rd_ready,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [dw-1:0]     wb_dat_o,
    output logic [dw/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [dw-1:0]     wb_dat_i
);

    localparam logic [bl-1:0]     c_max_burst = bl'(MAX_BURST);
    localparam logic [APP_AW-1:0] c_stride    = APP_AW'(dw / 8);

    logic [1:0]        r_state;
    logic [APP_AW-1:0] r_addr;
    logic [bl-1:0]     r_remaining;
    logic [bl-1:0]     r_burst_left;
    logic              r_single;
    logic              r_we;
    logic              r_err;

    logic          w_run;
    logic          w_stb;
    logic          w_ack;
    logic          w_last_beat;
    logic          w_stb_allow;
    logic          w_timeout;
    logic [bl-1:0] w_first_burst;
    logic [bl-1:0] w_next_burst;

    function automatic logic [bl-1:0] f_burst_len(input logic [bl-1:0] n);
        return (n > c_max_burst) ? c_max_burst : n;
    endfunction

    assign w_run         = (r_state == c_st_run);
    assign w_stb         = w_run & (r_we ? wd_valid : w_stb_allow);
    assign w_ack         = wb_ack_i & w_stb;
    assign w_last_beat   = (r_burst_left == bl'(1));
    assign w_first_burst = f_burst_len(cmd_len);
    assign w_next_burst  = f_burst_len(r_remaining);

    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            r_state      <= c_st_idle;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_burst_left <= '0;
            r_single     <= 1'b0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (cmd_valid) begin
                        r_addr       <= cmd_addr;
                        r_we         <= cmd_we;
                        r_remaining  <= cmd_len;
                        r_burst_left <= w_first_burst;
                        r_single     <= (w_first_burst == bl'(1));
                        r_err        <= 1'b0;
                        r_state      <= (cmd_len == '0) ? c_st_done : c_st_run;
                    end
                end
                c_st_run: begin
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= c_st_done;
                    end else if (w_ack) begin
                        r_addr       <= r_addr + c_stride;
                        r_remaining  <= r_remaining - bl'(1);
                        r_burst_left <= r_burst_left - bl'(1);
                        if (w_last_beat) begin
                            r_state <= (r_remaining == bl'(1)) ? c_st_done : c_st_gap;
                        end
                    end
                end
                c_st_gap: begin
                    r_burst_left <= w_next_burst;
                    r_single     <= (w_next_burst == bl'(1));
                    r_state      <= c_st_run;
                end
                c_st_done: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

`ifdef WBM_ACK_TIMEOUT_EN
    localparam int c_to_w = $clog2(TO_CYCLES + 1);

    logic [c_to_w-1:0] r_to_cnt;

    // Counts strobed cycles without ack; holds while the strobe is paused.
    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            r_to_cnt <= '0;
        end else if (!w_run || w_ack) begin
            r_to_cnt <= '0;
        end else if (w_stb) begin
            r_to_cnt <= r_to_cnt + c_to_w'(1);
        end
    end

    assign w_timeout = w_stb & ~wb_ack_i & (r_to_cnt == c_to_w'(TO_CYCLES - 1));
`else
    logic w_unused_to;

    assign w_unused_to = (TO_CYCLES == 0);
    assign w_timeout   = 1'b0;
`endif

    wbm_rd_skid #(
        .DW(dw)
    ) u_rd_skid (
        .clk        (wb_clk_i),
        .rst_n      (wb_resetn),
        .i_load     (w_ack & ~r_we),
        .i_data     (wb_dat_i),
        .i_ready    (rd_ready),
        .o_valid    (rd_valid),
        .o_data     (rd_data),
        .o_stb_allow(w_stb_allow)
    );

    assign cmd_ready = (r_state == c_st_idle);
    assign busy      = (r_state != c_st_idle);
    assign done      = (r_state == c_st_done);
    assign err       = done & r_err;
    assign wd_ready  = w_ack & r_we;
    assign wb_cyc_o  = w_run;
    assign wb_stb_o  = w_stb;
    assign wb_we_o   = r_we;
    assign wb_addr_o = r_addr;
    assign wb_dat_o  = wd_data;
    assign wb_sel_o  = '1;
    assign wb_cti_o  = !w_run      ? c_cti_classic :
                       r_single    ? c_cti_classic :
                       w_last_beat ? c_cti_eob     : c_cti_incr;

endmodule
`default_nettype wire
